// File: rtl/test_pattern_gen.sv
// test_pattern_gen: video test pattern generator with a one-cycle registered
// pipeline. Syncs, data-enable, video and the active pattern code leave together.
// Codes: 0 passthrough, 1 border, 2 vertical lines, 3 horizontal lines,
// 4 saturating ramp, 5 colour bars, 6 checkerboard.
// Defining TEST_PATTERN_AUTOCYCLE_EN adds code 7, which auto-cycles codes 1..6.
// Without that macro, code 7 is treated like every other undefined code (passthrough).
module test_pattern_gen #(
  parameter int B               = 8,
  parameter int X_BITS          = 13,
  parameter int Y_BITS          = 13,
  parameter int FRACTIONAL_BITS = 12,
  parameter int NUM_BARS        = 8,
  parameter int CHK_LOG2        = 5
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [X_BITS-1:0]            x,
  input  logic [Y_BITS-1:0]            y,
  input  logic                         vn_in,
  input  logic                         hn_in,
  input  logic                         dn_in,
  input  logic [B-1:0]                 r_in,
  input  logic [B-1:0]                 g_in,
  input  logic [B-1:0]                 b_in,
  input  logic [X_BITS-1:0]            total_active_pix,
  input  logic [Y_BITS-1:0]            total_active_lines,
  input  logic [7:0]                   pattern,
  input  logic [B+FRACTIONAL_BITS-1:0] ramp_step,
  input  logic [X_BITS-1:0]            bar_width,
  output logic                         vn_out,
  output logic                         hn_out,
  output logic                         den_out,
  output logic [B-1:0]                 r_out,
  output logic [B-1:0]                 g_out,
  output logic [B-1:0]                 b_out,
  output logic [7:0]                   active_pattern
);

  localparam int AW = B + FRACTIONAL_BITS;
  localparam logic [3:0] LAST_BAR = 4'(NUM_BARS - 1);

  logic              frameStart;
  logic [7:0]        latched_q, latched_d;
  logic [7:0]        effCode;
  logic [AW-1:0]     rampAcc_q, rampAcc_d;
  logic [AW:0]       rampSum;
  logic [X_BITS-1:0] barCnt_q, barCnt_d, barCntCur, barWidthM1;
  logic [3:0]        barIdx_q, barIdx_d, barIdxCur;
  logic              phase_q, phase_d;
  logic              onBorder;
  logic              chkWhite;
  logic [B-1:0]      rOut_q, rOut_d;
  logic [B-1:0]      gOut_q, gOut_d;
  logic [B-1:0]      bOut_q, bOut_d;
  logic              vnOut_q, hnOut_q, denOut_q;
  logic [7:0]        activePattern_q;

  // The first active pixel marks a frame boundary; the requested code is only sampled here.
  assign frameStart = (x == '0) && (y == '0) && dn_in;
  assign latched_d  = frameStart ? pattern : latched_q;

`ifdef TEST_PATTERN_AUTOCYCLE_EN
  typedef enum logic {HOLD, ADVANCE} cycleState_t;

  cycleState_t cycState_q, cycState_d;
  logic [6:0]  frameCnt_q, frameCnt_d;
  logic [2:0]  cycCode_q, cycCode_d;

  // Auto-cycle state register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cycState_q <= HOLD;
      frameCnt_q <= '0;
      cycCode_q  <= '0;
    end else begin
      cycState_q <= cycState_d;
      frameCnt_q <= frameCnt_d;
      cycCode_q  <= cycCode_d;
    end
  end

  // HOLD counts frame starts, the entry frame counting as one. Once 120 frames
  // have been seen, ADVANCE waits for the next frame start and steps the shown
  // code there, so a change never lands mid-frame.
  always_comb begin
    cycState_d = cycState_q;
    frameCnt_d = frameCnt_q;
    cycCode_d  = cycCode_q;
    if (latched_d != 8'd7) begin
      cycState_d = HOLD;
      frameCnt_d = '0;
      cycCode_d  = '0;
    end else if (frameStart) begin
      if (latched_q != 8'd7) begin
        cycState_d = HOLD;
        frameCnt_d = 7'd1;
        cycCode_d  = 3'd1;
      end else begin
        case (cycState_q)
          HOLD: begin
            frameCnt_d = frameCnt_q + 7'd1;
            if (frameCnt_q == 7'd119) begin
              cycState_d = ADVANCE;
            end
          end
          ADVANCE: begin
            cycCode_d  = (cycCode_q == 3'd6) ? 3'd1 : cycCode_q + 3'd1;
            frameCnt_d = 7'd1;
            cycState_d = HOLD;
          end
        endcase
      end
    end
  end

  assign effCode = (latched_d == 8'd7) ? {5'd0, cycCode_d} : latched_d;
`else
  assign effCode = latched_d;
`endif

  // Ramp accumulator restarts every line and saturates instead of wrapping.
  always_comb begin
    rampSum = {1'b0, rampAcc_q} + {1'b0, ramp_step};
    if (x == '0) begin
      rampAcc_d = ramp_step;
    end else if (dn_in) begin
      rampAcc_d = rampSum[AW] ? '1 : rampSum[AW-1:0];
    end else begin
      rampAcc_d = rampAcc_q;
    end
  end

  // Bar counters clear on column 0 so that pixel already belongs to bar 0;
  // a zero width behaves as one pixel per bar and the index sticks on the last bar.
  always_comb begin
    barWidthM1 = (bar_width == '0) ? '0 : bar_width - X_BITS'(1);
    barCntCur  = (x == '0) ? '0 : barCnt_q;
    barIdxCur  = (x == '0) ? '0 : barIdx_q;
    barCnt_d   = barCntCur;
    barIdx_d   = barIdxCur;
    if (dn_in) begin
      if (barCntCur == barWidthM1) begin
        barCnt_d = '0;
        if (barIdxCur != LAST_BAR) begin
          barIdx_d = barIdxCur + 4'd1;
        end
      end else begin
        barCnt_d = barCntCur + X_BITS'(1);
      end
    end
  end

  // Checker phase alternates on each frame start while the checkerboard keeps
  // running; the first frame of a checker run uses the current phase.
  assign phase_d  = (frameStart && (latched_q == 8'd6)) ? ~phase_q : phase_q;
  assign chkWhite = x[CHK_LOG2] ^ y[CHK_LOG2] ^ phase_d;
  assign onBorder = (y == '0) || (y == total_active_lines - Y_BITS'(1)) ||
                    (x == '0) || (x == total_active_pix - X_BITS'(1));

  // Pattern selection; generated codes blank outside the active area while
  // passthrough and unknown codes forward the upstream video untouched.
  always_comb begin
    rOut_d = r_in;
    gOut_d = g_in;
    bOut_d = b_in;
    case (effCode)
      8'd1: begin
        if (!dn_in) begin
          rOut_d = '0;
          gOut_d = '0;
          bOut_d = '0;
        end else if (onBorder) begin
          rOut_d = '1;
          gOut_d = '1;
          bOut_d = '1;
        end
      end
      8'd2: begin
        rOut_d = {B{dn_in & x[0]}};
        gOut_d = {B{dn_in & x[0]}};
        bOut_d = {B{dn_in & x[0]}};
      end
      8'd3: begin
        rOut_d = {B{dn_in & y[0]}};
        gOut_d = {B{dn_in & y[0]}};
        bOut_d = {B{dn_in & y[0]}};
      end
      8'd4: begin
        rOut_d = dn_in ? rampAcc_d[AW-1 -: B] : '0;
        gOut_d = dn_in ? rampAcc_d[AW-1 -: B] : '0;
        bOut_d = dn_in ? rampAcc_d[AW-1 -: B] : '0;
      end
      8'd5: begin
        rOut_d = {B{dn_in & barIdxCur[0]}};
        gOut_d = {B{dn_in & barIdxCur[1]}};
        bOut_d = {B{dn_in & barIdxCur[2]}};
      end
      8'd6: begin
        rOut_d = {B{dn_in & chkWhite}};
        gOut_d = {B{dn_in & chkWhite}};
        bOut_d = {B{dn_in & chkWhite}};
      end
      default: begin
      end
    endcase
  end

  // Pipeline and pattern state registers; reset overrides every update.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      latched_q       <= '0;
      activePattern_q <= '0;
      rampAcc_q       <= '0;
      barCnt_q        <= '0;
      barIdx_q        <= '0;
      phase_q         <= 1'b0;
      rOut_q          <= '0;
      gOut_q          <= '0;
      bOut_q          <= '0;
      vnOut_q         <= 1'b0;
      hnOut_q         <= 1'b0;
      denOut_q        <= 1'b0;
    end else begin
      latched_q       <= latched_d;
      activePattern_q <= effCode;
      rampAcc_q       <= rampAcc_d;
      barCnt_q        <= barCnt_d;
      barIdx_q        <= barIdx_d;
      phase_q         <= phase_d;
      rOut_q          <= rOut_d;
      gOut_q          <= gOut_d;
      bOut_q          <= bOut_d;
      vnOut_q         <= vn_in;
      hnOut_q         <= hn_in;
      denOut_q        <= dn_in;
    end
  end

  assign r_out          = rOut_q;
  assign g_out          = gOut_q;
  assign b_out          = bOut_q;
  assign vn_out         = vnOut_q;
  assign hn_out         = hnOut_q;
  assign den_out        = denOut_q;
  assign active_pattern = activePattern_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// tb_test_pattern_gen: directed-vector bench for test_pattern_gen.
// Inputs change on the falling edge; outputs are read on the following falling edge.
module tb_test_pattern_gen;

  localparam int B  = 8;
  localparam int XB = 13;
  localparam int YB = 13;
  localparam int FB = 12;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic          vn_in, hn_in, dn_in;
  logic [B-1:0]  r_in, g_in, b_in;
  logic [XB-1:0] total_active_pix;
  logic [YB-1:0] total_active_lines;
  logic [7:0]    pattern;
  logic [B+FB-1:0] ramp_step;
  logic [XB-1:0] bar_width;
  logic          vn_out, hn_out, den_out;
  logic [B-1:0]  r_out, g_out, b_out;
  logic [7:0]    active_pattern;

  int checkCount = 0;
  int failCount  = 0;

  test_pattern_gen dut (
    .clk_in             (clk_in),
    .reset              (reset),
    .x                  (x),
    .y                  (y),
    .vn_in              (vn_in),
    .hn_in              (hn_in),
    .dn_in              (dn_in),
    .r_in               (r_in),
    .g_in               (g_in),
    .b_in               (b_in),
    .total_active_pix   (total_active_pix),
    .total_active_lines (total_active_lines),
    .pattern            (pattern),
    .ramp_step          (ramp_step),
    .bar_width          (bar_width),
    .vn_out             (vn_out),
    .hn_out             (hn_out),
    .den_out            (den_out),
    .r_out              (r_out),
    .g_out              (g_out),
    .b_out              (b_out),
    .active_pattern     (active_pattern)
  );

  // Free-running pixel clock.
  always #5 clk_in = ~clk_in;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRgb(input string tag, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    checkOutput({tag, "_r"}, r_out, er);
    checkOutput({tag, "_g"}, g_out, eg);
    checkOutput({tag, "_b"}, b_out, eb);
  endtask

  // Drives one pixel: upstream video r=x+17, g=3y+40, b=x^0xC3; hsync=x[0], vsync=y[0].
  task automatic applyStimulus(input int px, input int py, input logic de);
    x     = XB'(px);
    y     = YB'(py);
    dn_in = de;
    hn_in = px[0];
    vn_in = py[0];
    r_in  = 8'(px + 17);
    g_in  = 8'(py * 3 + 40);
    b_in  = 8'(px ^ 8'hC3);
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    failCount++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

  // Directed scenarios.
  initial begin
    logic [2:0] idx;
    reset              = 1'b1;
    pattern            = 8'd5;
    ramp_step          = '0;
    bar_width          = 13'd2;
    total_active_pix   = 13'd8;
    total_active_lines = 13'd4;
    @(negedge clk_in);

    $display("[TB] reset state");
    applyStimulus(3, 1, 1'b1);
    applyStimulus(5, 1, 1'b1);
    checkRgb("reset_rgb", 8'h00, 8'h00, 8'h00);
    checkOutput("reset_den", den_out, 0);
    checkOutput("reset_hn", hn_out, 0);
    checkOutput("reset_vn", vn_out, 0);
    checkOutput("reset_ap", active_pattern, 0);
    reset = 1'b0;

    $display("[TB] bars with width 2, then mid-frame reset");
    applyStimulus(0, 0, 1'b1);
    checkOutput("bar_ap", active_pattern, 5);
    checkRgb("bar_x0", 8'h00, 8'h00, 8'h00);
    applyStimulus(1, 0, 1'b1);
    applyStimulus(2, 0, 1'b1);
    checkRgb("bar_x2", 8'hFF, 8'h00, 8'h00);
    applyStimulus(3, 0, 1'b1);
    applyStimulus(4, 0, 1'b1);
    checkRgb("bar_x4", 8'h00, 8'hFF, 8'h00);
    applyStimulus(5, 0, 1'b1);
    reset = 1'b1;
    applyStimulus(6, 0, 1'b1);
    applyStimulus(7, 0, 1'b1);
    applyStimulus(0, 1, 1'b1);
    checkRgb("midrst_rgb", 8'h00, 8'h00, 8'h00);
    checkOutput("midrst_ap", active_pattern, 0);
    checkOutput("midrst_den", den_out, 0);
    reset = 1'b0;
    applyStimulus(1, 1, 1'b1);
    checkRgb("postrst_pass", 8'h12, 8'h2B, 8'hC2);
    checkOutput("postrst_den", den_out, 1);
    checkOutput("postrst_hn", hn_out, 1);
    checkOutput("postrst_vn", vn_out, 1);
    applyStimulus(2, 1, 1'b1);
    applyStimulus(0, 0, 1'b1);
    checkOutput("postrst_ap", active_pattern, 5);
    checkRgb("postrst_x0", 8'h00, 8'h00, 8'h00);
    applyStimulus(1, 0, 1'b1);
    applyStimulus(2, 0, 1'b1);
    checkRgb("postrst_x2", 8'hFF, 8'h00, 8'h00);

    $display("[TB] saturating ramp");
    pattern   = 8'd4;
    ramp_step = 20'h10000;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i, 0, 1'b1);
      checkOutput($sformatf("ramp_r_x%0d", i), r_out, (i < 15) ? (i + 1) * 16 : 255);
    end
    checkOutput("ramp_g_x19", g_out, 8'hFF);
    checkOutput("ramp_b_x19", b_out, 8'hFF);
    applyStimulus(20, 0, 1'b0);
    checkOutput("ramp_blank_r", r_out, 0);
    checkOutput("ramp_blank_den", den_out, 0);

    $display("[TB] colour bars 160 wide over 1280 pixels");
    pattern          = 8'd5;
    bar_width        = 13'd160;
    total_active_pix = 13'd1280;
    for (int i = 0; i < 1280; i++) begin
      applyStimulus(i, 0, 1'b1);
      if ((i % 160 == 0) || (i % 160 == 159)) begin
        idx = 3'(i / 160);
        checkRgb($sformatf("bars160_x%0d", i), {8{idx[0]}}, {8{idx[1]}}, {8{idx[2]}});
      end
    end

    $display("[TB] colour bars with zero width");
    bar_width = 13'd0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(i, 0, 1'b1);
      idx = (i > 7) ? 3'd7 : 3'(i);
      checkRgb($sformatf("bars0_x%0d", i), {8{idx[0]}}, {8{idx[1]}}, {8{idx[2]}});
    end

    $display("[TB] pattern change mid-frame");
    pattern            = 8'd2;
    total_active_pix   = 13'd8;
    total_active_lines = 13'd4;
    applyStimulus(0, 0, 1'b1);
    checkOutput("vlines_ap", active_pattern, 2);
    checkOutput("vlines_x0", r_out, 8'h00);
    applyStimulus(1, 0, 1'b1);
    checkOutput("vlines_x1", r_out, 8'hFF);
    applyStimulus(1, 1, 1'b0);
    checkOutput("vlines_blank", r_out, 8'h00);
    pattern = 8'd3;
    applyStimulus(1, 2, 1'b1);
    checkOutput("switch_hold_x1", r_out, 8'hFF);
    checkOutput("switch_hold_ap", active_pattern, 2);
    applyStimulus(2, 3, 1'b1);
    checkOutput("switch_hold_y3", r_out, 8'h00);
    applyStimulus(0, 0, 1'b1);
    checkOutput("hlines_ap", active_pattern, 3);
    checkOutput("hlines_y0", r_out, 8'h00);
    applyStimulus(2, 1, 1'b1);
    checkOutput("hlines_y1", r_out, 8'hFF);
    applyStimulus(3, 2, 1'b1);
    checkOutput("hlines_y2", r_out, 8'h00);

    $display("[TB] border");
    pattern = 8'd1;
    applyStimulus(0, 0, 1'b1);
    checkRgb("border_00", 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(3, 1, 1'b1);
    checkRgb("border_inner", 8'h14, 8'h2B, 8'hC0);
    applyStimulus(7, 2, 1'b1);
    checkRgb("border_right", 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(4, 3, 1'b1);
    checkRgb("border_bottom", 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(3, 2, 1'b0);
    checkRgb("border_blank", 8'h00, 8'h00, 8'h00);

    $display("[TB] checkerboard over two frames");
    reset = 1'b1;
    applyStimulus(5, 5, 1'b1);
    reset              = 1'b0;
    pattern            = 8'd6;
    total_active_pix   = 13'd64;
    total_active_lines = 13'd64;
    applyStimulus(0, 0, 1'b1);
    checkOutput("chk_f1_0_0", r_out, 8'h00);
    applyStimulus(32, 0, 1'b1);
    checkOutput("chk_f1_32_0", r_out, 8'hFF);
    applyStimulus(32, 32, 1'b1);
    checkOutput("chk_f1_32_32", g_out, 8'h00);
    applyStimulus(0, 32, 1'b1);
    checkOutput("chk_f1_0_32", b_out, 8'hFF);
    applyStimulus(0, 0, 1'b1);
    checkOutput("chk_f2_0_0", r_out, 8'hFF);
    applyStimulus(32, 0, 1'b1);
    checkOutput("chk_f2_32_0", r_out, 8'h00);

`ifdef TEST_PATTERN_AUTOCYCLE_EN
    $display("[TB] auto-cycle over one-pixel frames");
    pattern = 8'd7;
    for (int f = 1; f <= 721; f++) begin
      applyStimulus(0, 0, 1'b1);
      case (f)
        1, 120:  checkOutput($sformatf("auto_f%0d", f), active_pattern, 1);
        121:     checkOutput("auto_f121", active_pattern, 2);
        601:     checkOutput("auto_f601", active_pattern, 6);
        721:     checkOutput("auto_f721", active_pattern, 1);
        default: begin
        end
      endcase
    end
`else
    $display("[TB] code 7 without auto-cycle");
    pattern = 8'd7;
    applyStimulus(0, 0, 1'b1);
    checkOutput("code7_ap", active_pattern, 7);
    checkRgb("code7_pass", 8'h11, 8'h28, 8'hC3);
`endif

    $display("[TB] undefined code");
    pattern = 8'd200;
    applyStimulus(0, 0, 1'b1);
    checkOutput("code200_ap", active_pattern, 200);
    checkRgb("code200_pass", 8'h11, 8'h28, 8'hC3);
    applyStimulus(1, 0, 1'b0);
    checkRgb("code200_blank_pass", 8'h12, 8'h28, 8'hC2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
